riscv_test_monitor: RTL and testbench

- Synthesizable pass/fail monitor for riscv-tests runs on the pipelined core; replaces the ad-hoc PC/gp check in per-test benches.
- Watches fetch PC, register write-back and data-memory stores. Decides PASS/FAIL/TIMEOUT using the gp-register convention, the tohost-store convention, or both.
- Sits beside Core in every test bench. It is also usable on FPGA to drive a status LED or UART.

---
 rtl/riscv_test_monitor_if.sv | 37 +++
 rtl/riscv_test_monitor.sv | 128 ++++++++++++
 tb/tb_riscv_test_monitor.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_test_monitor_if.sv
// Observation bundle between the core (fetch, write-back, store ports) and the
// riscv-tests pass/fail monitor, plus the monitor's verdict outputs.
interface riscv_test_monitor_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32
) ();

   logic              mon_en;
   logic [XLEN-1:0]   if_pc;
   logic              if_valid;
   logic              wb_en;
   logic [4:0]        wb_idx;
   logic [XLEN-1:0]   wb_data;
   logic              st_en;
   logic [XLEN-1:0]   st_addr;
   logic [XLEN-1:0]   st_data;

   logic              done;
   logic              pass;
   logic              fail;
   logic              timeout;
   logic [XLEN-2:0]   fail_num;
   logic [CNT_W-1:0]  cycle_count;

   // Core / bench side: drives the observed pipeline signals.
   modport master (
      output mon_en, if_pc, if_valid, wb_en, wb_idx, wb_data, st_en, st_addr, st_data,
      input  done, pass, fail, timeout, fail_num, cycle_count
   );

   // Monitor side.
   modport slave (
      input  mon_en, if_pc, if_valid, wb_en, wb_idx, wb_data, st_en, st_addr, st_data,
      output done, pass, fail, timeout, fail_num, cycle_count
   );

endinterface

// File: rtl/riscv_test_monitor.sv
// riscv-tests pass/fail/timeout monitor: decides a sticky verdict from the gp
// register convention at PASS_PC, the tohost store convention, or both.
module riscv_test_monitor #(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] PASS_PC     = XLEN'(32'h44),
   parameter int unsigned     GP_IDX      = 3,
   parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(32'h1000),
   parameter int unsigned     MODE        = 2,
   parameter int unsigned     TIMEOUT     = 6000,
   parameter int unsigned     CNT_W       = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   riscv_test_monitor_if.slave   mon
);

   localparam logic [4:0]       GP_REG   = 5'(GP_IDX);
   localparam bit               USE_GP   = (MODE != 1);
   localparam bit               USE_TH   = (MODE != 0);
   localparam bit               TO_EN    = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [XLEN-1:0]  ONE      = XLEN'(1);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_PASS    = 2'd1,
      ST_FAIL    = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_e;

   state_e            state_q,       state_d;
   logic [XLEN-1:0]   shadow_gp_q,   shadow_gp_d;
   logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
   logic [XLEN-2:0]   fail_num_q,    fail_num_d;
   logic              done_q,        done_d;
   logic              pass_q,        pass_d;
   logic              fail_q,        fail_d;
   logic              timeout_q,     timeout_d;

   logic              run;
   logic              gp_wr;
   logic [XLEN-1:0]   gp_eff;
   logic              gp_hit;
   logic              th_hit;
   logic              to_hit;

   // Trigger decode; a same-cycle gp write bypasses the shadow copy.
   always_comb begin
      run    = (state_q == ST_RUN) && mon.mon_en;
      gp_wr  = mon.wb_en && (mon.wb_idx == GP_REG) && (mon.wb_idx != 5'd0);
      gp_eff = gp_wr ? mon.wb_data : shadow_gp_q;
      gp_hit = USE_GP && run && mon.if_valid && (mon.if_pc == PASS_PC);
      th_hit = USE_TH && run && mon.st_en && (mon.st_addr == TOHOST_ADDR) && mon.st_data[0];
      to_hit = TO_EN && run && (cycle_count_q == CNT_LAST);
   end

   // Next state: tohost beats gp, any verdict beats timeout.
   always_comb begin
      state_d       = state_q;
      shadow_gp_d   = shadow_gp_q;
      cycle_count_d = cycle_count_q;
      fail_num_d    = fail_num_q;

      if ((state_q == ST_RUN) && gp_wr) begin
         shadow_gp_d = mon.wb_data;
      end

      if (run) begin
         if (cycle_count_q != CNT_MAX) begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
         end

         if (th_hit) begin
            if (mon.st_data == ONE) begin
               state_d = ST_PASS;
            end else begin
               state_d    = ST_FAIL;
               fail_num_d = mon.st_data[XLEN-1:1];
            end
         end else if (gp_hit) begin
            if (gp_eff == ONE) begin
               state_d = ST_PASS;
            end else begin
               state_d    = ST_FAIL;
               fail_num_d = gp_eff[XLEN-1:1];
            end
         end else if (to_hit) begin
            state_d = ST_TIMEOUT;
         end
      end

      done_d    = (state_d != ST_RUN);
      pass_d    = (state_d == ST_PASS);
      fail_d    = (state_d == ST_FAIL);
      timeout_d = (state_d == ST_TIMEOUT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_RUN;
         shadow_gp_q   <= '0;
         cycle_count_q <= '0;
         fail_num_q    <= '0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         fail_q        <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         shadow_gp_q   <= shadow_gp_d;
         cycle_count_q <= cycle_count_d;
         fail_num_q    <= fail_num_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
         fail_q        <= fail_d;
         timeout_q     <= timeout_d;
      end
   end

   assign mon.done        = done_q;
   assign mon.pass        = pass_q;
   assign mon.fail        = fail_q;
   assign mon.timeout     = timeout_q;
   assign mon.fail_num    = fail_num_q;
   assign mon.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Scoreboard bench for riscv_test_monitor: three instances (MODE 0, MODE 1,
// MODE 2 with TIMEOUT 20) share one stimulus stream; verdicts are checked on done.
module tb_riscv_test_monitor;

   localparam int NDUT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mon_en = 1'b1;
   logic [31:0] if_pc = '0;
   logic        if_valid = 1'b0;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_idx = '0;
   logic [31:0] wb_data = '0;
   logic        st_en = 1'b0;
   logic [31:0] st_addr = '0;
   logic [31:0] st_data = '0;

   logic [NDUT-1:0] done_v, pass_v, fail_v, to_v;
   logic [30:0]     fn_v [NDUT];
   logic [31:0]     cc_v [NDUT];

   always #5 clk = ~clk;

   riscv_test_monitor_if ifs [NDUT] ();

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      assign ifs[g].mon_en   = mon_en;
      assign ifs[g].if_pc    = if_pc;
      assign ifs[g].if_valid = if_valid;
      assign ifs[g].wb_en    = wb_en;
      assign ifs[g].wb_idx   = wb_idx;
      assign ifs[g].wb_data  = wb_data;
      assign ifs[g].st_en    = st_en;
      assign ifs[g].st_addr  = st_addr;
      assign ifs[g].st_data  = st_data;
      assign done_v[g] = ifs[g].done;
      assign pass_v[g] = ifs[g].pass;
      assign fail_v[g] = ifs[g].fail;
      assign to_v[g]   = ifs[g].timeout;
      assign fn_v[g]   = ifs[g].fail_num;
      assign cc_v[g]   = ifs[g].cycle_count;

      riscv_test_monitor #(
         .MODE    ((g == 0) ? 0 : ((g == 1) ? 1 : 2)),
         .TIMEOUT ((g == 2) ? 20 : 0)
      ) u_dut (
         .clk (clk),
         .rst (rst),
         .mon (ifs[g])
      );
   end

   typedef struct {
      string       nm;
      logic        p;
      logic        f;
      logic        t;
      logic [30:0] fn;
      logic [31:0] cc;
   } exp_t;

   exp_t q0[$], q1[$], q2[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic expect_v(int k, string nm, logic p, logic f, logic t,
                           logic [30:0] fn, logic [31:0] cc);
      exp_t e;
      e.nm = nm; e.p = p; e.f = f; e.t = t; e.fn = fn; e.cc = cc;
      case (k)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   function automatic int qsize(int k);
      case (k)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   // Monitor: each rising done pops the oldest expectation of that instance.
   logic [NDUT-1:0] seen = '0;
   always @(negedge clk) begin
      for (int k = 0; k < NDUT; k++) begin
         if (!done_v[k]) begin
            seen[k] <= 1'b0;
         end else if (!seen[k]) begin
            seen[k] <= 1'b1;
            if (qsize(k) == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_verdict d%0d: actual done=1 p=%0b f=%0b t=%0b required done=0",
                        k, pass_v[k], fail_v[k], to_v[k]);
            end else begin
               exp_t e;
               case (k)
                  0:       e = q0.pop_front();
                  1:       e = q1.pop_front();
                  default: e = q2.pop_front();
               endcase
               chk($sformatf("%s d%0d pass", e.nm, k),     32'(pass_v[k]), 32'(e.p));
               chk($sformatf("%s d%0d fail", e.nm, k),     32'(fail_v[k]), 32'(e.f));
               chk($sformatf("%s d%0d timeout", e.nm, k),  32'(to_v[k]),   32'(e.t));
               chk($sformatf("%s d%0d fail_num", e.nm, k), 32'(fn_v[k]),   32'(e.fn));
               chk($sformatf("%s d%0d cycles", e.nm, k),   cc_v[k],        e.cc);
            end
         end
      end
   end

   task automatic snap(int k, string nm, logic d, logic p, logic f, logic t,
                       logic [30:0] fn, logic [31:0] cc);
      chk($sformatf("%s d%0d done", nm, k),     32'(done_v[k]), 32'(d));
      chk($sformatf("%s d%0d pass", nm, k),     32'(pass_v[k]), 32'(p));
      chk($sformatf("%s d%0d fail", nm, k),     32'(fail_v[k]), 32'(f));
      chk($sformatf("%s d%0d timeout", nm, k),  32'(to_v[k]),   32'(t));
      chk($sformatf("%s d%0d fail_num", nm, k), 32'(fn_v[k]),   32'(fn));
      chk($sformatf("%s d%0d cycles", nm, k),   cc_v[k],        cc);
   endtask

   task automatic drain(string nm);
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("%s d%0d pending_verdicts", nm, k), 32'(qsize(k)), 32'd0);
      end
      q0.delete(); q1.delete(); q2.delete();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      wb_en = 1'b0; st_en = 1'b0; if_valid = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) step();
   endtask

   task automatic cyc_wb(logic [4:0] idx, logic [31:0] d);
      wb_en = 1'b1; wb_idx = idx; wb_data = d;
      step(); clr();
   endtask

   task automatic cyc_pc();
      if_valid = 1'b1; if_pc = 32'h44;
      step(); clr();
   endtask

   task automatic cyc_st(logic [31:0] a, logic [31:0] d);
      st_en = 1'b1; st_addr = a; st_data = d;
      step(); clr();
   endtask

   task automatic do_reset();
      clr();
      mon_en = 1'b1;
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   initial begin
      do_reset();
      for (int k = 0; k < NDUT; k++) snap(k, "reset", 0, 0, 0, 0, 31'd0, 32'd0);

      // gp pass; a write to a non-gp register must not disturb the shadow
      cyc_wb(5'd3, 32'd1);
      cyc_wb(5'd4, 32'd9);
      expect_v(0, "gp_pass", 1, 0, 0, 31'd0, 32'd3);
      expect_v(2, "gp_pass", 1, 0, 0, 31'd0, 32'd3);
      cyc_pc();
      idle(3);
      snap(0, "gp_pass_frozen", 1, 1, 0, 0, 31'd0, 32'd3);
      snap(1, "gp_ignored_mode1", 0, 0, 0, 0, 31'd0, 32'd6);
      drain("gp_pass");

      do_reset();
      cyc_wb(5'd3, 32'h0000000B);
      expect_v(0, "gp_fail", 0, 1, 0, 31'd5, 32'd2);
      expect_v(2, "gp_fail", 0, 1, 0, 31'd5, 32'd2);
      cyc_pc();
      idle(2);
      drain("gp_fail");

      // same-cycle gp write overrides the shadow value
      do_reset();
      cyc_wb(5'd3, 32'd1);
      expect_v(0, "gp_bypass", 0, 1, 0, 31'd6, 32'd2);
      expect_v(2, "gp_bypass", 0, 1, 0, 31'd6, 32'd2);
      wb_en = 1'b1; wb_idx = 5'd3; wb_data = 32'h0000000D;
      if_valid = 1'b1; if_pc = 32'h44;
      step(); clr();
      idle(2);
      drain("gp_bypass");

      // tohost: even data and wrong address ignored, odd fails, later pass ignored
      do_reset();
      cyc_st(32'h1000, 32'd2);
      cyc_st(32'h1004, 32'd7);
      expect_v(1, "th_fail", 0, 1, 0, 31'd3, 32'd3);
      expect_v(2, "th_fail", 0, 1, 0, 31'd3, 32'd3);
      cyc_st(32'h1000, 32'd7);
      cyc_st(32'h1000, 32'd1);
      idle(2);
      snap(1, "th_sticky", 1, 0, 1, 0, 31'd3, 32'd3);
      snap(0, "th_ignored_mode0", 0, 0, 0, 0, 31'd0, 32'd6);
      drain("th_fail");

      // simultaneous gp pass and tohost fail
      do_reset();
      cyc_wb(5'd3, 32'd1);
      expect_v(0, "both", 1, 0, 0, 31'd0, 32'd2);
      expect_v(1, "both", 0, 1, 0, 31'd2, 32'd2);
      expect_v(2, "both", 0, 1, 0, 31'd2, 32'd2);
      if_valid = 1'b1; if_pc = 32'h44;
      st_en = 1'b1; st_addr = 32'h1000; st_data = 32'd5;
      step(); clr();
      idle(2);
      drain("both");

      // timeout with a paused window; gp write while paused is still tracked
      do_reset();
      idle(10);
      mon_en = 1'b0;
      cyc_wb(5'd3, 32'd1);
      cyc_pc();
      idle(3);
      mon_en = 1'b1;
      expect_v(2, "timeout", 0, 0, 1, 31'd0, 32'd20);
      idle(10);
      expect_v(0, "paused_gp", 1, 0, 0, 31'd0, 32'd21);
      cyc_pc();
      idle(2);
      snap(1, "no_timeout_mode1", 0, 0, 0, 0, 31'd0, 32'd23);
      snap(2, "timeout_frozen", 1, 0, 0, 1, 31'd0, 32'd20);
      drain("timeout");

      // verdict on the last pre-timeout cycle wins
      do_reset();
      idle(19);
      expect_v(0, "pass_at_19", 1, 0, 0, 31'd0, 32'd20);
      expect_v(2, "pass_at_19", 1, 0, 0, 31'd0, 32'd20);
      wb_en = 1'b1; wb_idx = 5'd3; wb_data = 32'd1;
      if_valid = 1'b1; if_pc = 32'h44;
      step(); clr();
      idle(2);
      snap(1, "pass_at_19_mode1", 0, 0, 0, 0, 31'd0, 32'd22);
      drain("pass_at_19");

      // half-cycle async reset after pass, then a fresh run
      do_reset();
      cyc_wb(5'd3, 32'd1);
      expect_v(0, "pre_pulse", 1, 0, 0, 31'd0, 32'd2);
      expect_v(2, "pre_pulse", 1, 0, 0, 31'd0, 32'd2);
      cyc_pc();
      idle(2);
      drain("pre_pulse");
      #1 rst = 1'b0;
      #2;
      for (int k = 0; k < NDUT; k++) snap(k, "async_reset", 0, 0, 0, 0, 31'd0, 32'd0);
      #3 rst = 1'b1;
      expect_v(1, "fresh_run", 1, 0, 0, 31'd0, 32'd1);
      expect_v(2, "fresh_run", 1, 0, 0, 31'd0, 32'd1);
      cyc_st(32'h1000, 32'd1);
      idle(2);
      snap(0, "fresh_run_mode0", 0, 0, 0, 0, 31'd0, 32'd3);
      drain("fresh_run");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
